optic_flow_accumulate_ci: RTL and testbench
===========================================

Name: optic_flow_accumulate_ci

Overview:
Multi-cycle custom instruction that consumes the packed optic-flow words produced by the optic flow CI. Each word carries 8 pixels x 4 bits: per nibble, bit0 right, bit1 left, bit2 down, bit3 up. The block accumulates per-direction totals over a frame so that software reads four counters instead of popcounting 4 bits per pixel. It sits on the CPU custom-instruction bus beside the optic flow CI and uses the same start/done/result protocol.

Parameters:
customInstructionId, 8'd0, ciN value this block responds to.
COUNTER_WIDTH, 24, width of each direction counter and the word counter (range 4..31).

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  CI start strobe, single cycle.
valueA  input  32  operand A: flow word (ACCUMULATE) or read select in bits [2:0] (READ).
valueB  input  32  operand B: bits [1:0] = opcode; bits [31:2] ignored.
ciN  input  8  custom-instruction number.
done  output  1  single-cycle completion pulse.
result  output  32  result value; 32'd0 whenever done is low.

Behaviour:
- Activation: a command is accepted only when start=1, ciN==customInstructionId and the FSM is IDLE. start with another ciN is ignored: no done, no state change.
- Opcodes (valueB[1:0]): 0 CLEAR, 1 ACCUMULATE, 2 READ, 3 NOP.
- Registers: cntR, cntL, cntD, cntU and cntW (words accumulated), each COUNTER_WIDTH bits, unsigned, saturating at 2^COUNTER_WIDTH-1 (no wrap).
- FSM states: IDLE, ADD, RESP.
- IDLE, CLEAR accepted: all five counters go to 0 at that edge; next state RESP.
- IDLE, ACCUMULATE accepted: valueA latched into wordReg; next state ADD.
- IDLE, READ accepted: the selected value is latched into resultReg; next state RESP.
- IDLE, NOP accepted: next state RESP.
- ADD: popcount nibble bit0 over the 8 nibbles into pR (0..8); do the same for bits 1, 2 and 3 into pL, pD, pU. At this edge cntX <= min(cntX + pX, max) and cntW <= min(cntW + 1, max). Next state RESP.
- RESP: done=1 and result=resultReg for exactly this cycle. Next state IDLE.
- Latency from the accepting start edge: CLEAR, READ and NOP give done 1 cycle later; ACCUMULATE gives done 2 cycles later. Back-to-back: a new start is accepted in the cycle after the RESP cycle at the earliest.
- start while in ADD or RESP: ignored. The command is not queued and no second done is produced.
- resultReg: zero-extended counter value for selects 0-3 and 6. Selects:
  - 0 cntR, 1 cntL, 2 cntD, 3 cntU.
  - 4 netH = cntR - cntL, computed as COUNTER_WIDTH+1-bit signed and sign-extended to 32 bits.
  - 5 netV = cntD - cntU, same width rules as netH.
  - 6 cntW.
  - 7 returns 32'd0.
  - For CLEAR, ACCUMULATE and NOP, resultReg = 0.
- READ samples the counters as they stand at the accepting edge.
- Reset (asynchronous, any state, including mid-ACCUMULATE): FSM to IDLE, done=0, result=0, all counters, wordReg and resultReg to 0. A pending accumulate is discarded.
- done and result are registered outputs. result is forced to 0 whenever done=0.

Test Plan:
- Reset, then READ each select 0-7 -> every done pulse arrives 1 cycle after start with result 0. done and result stay 0 while idle.
- CLEAR; ACCUMULATE 0xFFFFFFFF -> done 2 cycles after start. Then READ selects 0-3 -> 8 each; select 6 -> 1; selects 4/5 -> 0.
- CLEAR; ACCUMULATE 0x12481248 -> selects 0-3 each read 2. Then ACCUMULATE 0x22222222 twice -> select 1 reads 18, select 4 reads 0xFFFFFFF0 (2-18=-16).
- COUNTER_WIDTH=4: ACCUMULATE 0xFFFFFFFF twice -> selects 0-3 read 15 (saturated, not 0). After 20 accumulates select 6 reads 15.
- start with ciN != customInstructionId, and start pulsed during ADD -> no done and counters unchanged. A start pulsed during ADD produces exactly one done.
- Assert reset in the ADD cycle of ACCUMULATE 0xFFFFFFFF -> no done. A following READ of select 0 returns 0 and select 6 returns 0.

Source files
------------

// File: rtl/optic_flow_accumulate_ci_if.sv
// Custom-instruction bus carrying the start/done/result handshake and operands
// for the optic flow accumulate CI.
interface optic_flow_accumulate_ci_if;
  logic        start;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [7:0]  ciN;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, valueA, valueB, ciN,
    input  done, result
  );

  modport slave (
    input  start, valueA, valueB, ciN,
    output done, result
  );
endinterface

// File: rtl/optic_flow_accumulate_ci.sv
// Accumulates per-direction optic-flow counts (right/left/down/up) and a word count
// over a frame; software clears, accumulates packed flow words and reads totals.
module optic_flow_accumulate_ci #(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned COUNTER_WIDTH       = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  optic_flow_accumulate_ci_if.slave ci
);

  localparam int unsigned Cw   = COUNTER_WIDTH;
  localparam int unsigned CwP1 = COUNTER_WIDTH + 1;

  typedef logic [Cw-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  localparam logic [1:0] OpClear = 2'd0;
  localparam logic [1:0] OpAcc   = 2'd1;
  localparam logic [1:0] OpRead  = 2'd2;

  typedef enum logic [1:0] {StIdle, StAdd, StResp} state_e;

  state_e             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [31:0]        res_q, res_d;
  logic [3:0][Cw-1:0] cnt_q, cnt_d;   // 0 right, 1 left, 2 down, 3 up
  cnt_t               cntw_q, cntw_d;
  logic               done_q;
  logic [31:0]        res_out_q;

  logic [3:0][3:0]    pop;
  logic signed [Cw:0] net_h, net_v;
  logic [31:0]        read_val;
  logic               accept;
  logic               unused_b;

  assign unused_b = ^ci.valueB[31:2];

  function automatic cnt_t sat_add(input cnt_t a, input logic [3:0] p);
    logic [Cw:0] s;
    s = {1'b0, a} + CwP1'(p);
    return s[Cw] ? CntMax : s[Cw-1:0];
  endfunction

  // Bit b of every nibble counts toward direction b.
  always_comb begin
    pop = '0;
    for (int n = 0; n < 8; n++) begin
      for (int b = 0; b < 4; b++) begin
        pop[b] = pop[b] + 4'(word_q[4*n+b]);
      end
    end
  end

  assign net_h = $signed({1'b0, cnt_q[0]}) - $signed({1'b0, cnt_q[1]});
  assign net_v = $signed({1'b0, cnt_q[2]}) - $signed({1'b0, cnt_q[3]});

  always_comb begin
    read_val = '0;
    unique case (ci.valueA[2:0])
      3'd0:    read_val = 32'(cnt_q[0]);
      3'd1:    read_val = 32'(cnt_q[1]);
      3'd2:    read_val = 32'(cnt_q[2]);
      3'd3:    read_val = 32'(cnt_q[3]);
      3'd4:    read_val = 32'(net_h);
      3'd5:    read_val = 32'(net_v);
      3'd6:    read_val = 32'(cntw_q);
      default: read_val = '0;
    endcase
  end

  assign accept = ci.start && (ci.ciN == customInstructionId) && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cntw_d  = cntw_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          res_d   = '0;
          state_d = StResp;
          unique case (ci.valueB[1:0])
            OpClear: begin
              cnt_d  = '0;
              cntw_d = '0;
            end
            OpAcc: begin
              word_d  = ci.valueA;
              state_d = StAdd;
            end
            OpRead:  res_d = read_val;
            default: ;
          endcase
        end
      end
      StAdd: begin
        for (int b = 0; b < 4; b++) begin
          cnt_d[b] = sat_add(cnt_q[b], pop[b]);
        end
        cntw_d  = sat_add(cntw_q, 4'd1);
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      word_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      cntw_q    <= '0;
      done_q    <= 1'b0;
      res_out_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      cntw_q    <= cntw_d;
      // Outputs are registered so done/result line up with the RESP state.
      done_q    <= (state_d == StResp);
      res_out_q <= (state_d == StResp) ? res_d : '0;
    end
  end

  assign ci.done   = done_q;
  assign ci.result = res_out_q;

endmodule

// File: tb/tb_optic_flow_accumulate_ci.sv
// Drives identical commands into a 24-bit and a 4-bit counter instance and checks
// both against a frame-level reference model of the accumulator.
module tb_optic_flow_accumulate_ci;

  logic clock = 1'b0;
  logic reset = 1'b1;

  optic_flow_accumulate_ci_if bus24 ();
  optic_flow_accumulate_ci_if bus4 ();

  optic_flow_accumulate_ci #(
    .customInstructionId(8'd0),
    .COUNTER_WIDTH      (24)
  ) u_dut24 (
    .clock(clock),
    .reset(reset),
    .ci   (bus24)
  );

  optic_flow_accumulate_ci #(
    .customInstructionId(8'd0),
    .COUNTER_WIDTH      (4)
  ) u_dut4 (
    .clock(clock),
    .reset(reset),
    .ci   (bus4)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state per instance: [0..3] direction totals, [4] word count.
  longint m_cnt[2][5];
  int     m_wid[2] = '{24, 4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 5; i++) m_cnt[k][i] = 0;
  endfunction

  function automatic void m_acc(input logic [31:0] a);
    for (int k = 0; k < 2; k++) begin
      longint maxv = (longint'(1) << m_wid[k]) - 1;
      for (int b = 0; b < 4; b++) begin
        longint p = 0;
        for (int n = 0; n < 8; n++) p += longint'(a[4*n+b]);
        m_cnt[k][b] = (m_cnt[k][b] + p > maxv) ? maxv : m_cnt[k][b] + p;
      end
      m_cnt[k][4] = (m_cnt[k][4] + 1 > maxv) ? maxv : m_cnt[k][4] + 1;
    end
  endfunction

  function automatic logic [31:0] m_read(input int k, input int sel);
    case (sel)
      0, 1, 2, 3: return 32'(m_cnt[k][sel]);
      4:          return 32'(m_cnt[k][0] - m_cnt[k][1]);
      5:          return 32'(m_cnt[k][2] - m_cnt[k][3]);
      6:          return 32'(m_cnt[k][4]);
      default:    return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] c);
    bus24.start = st; bus24.valueA = a; bus24.valueB = b; bus24.ciN = c;
    bus4.start  = st; bus4.valueA  = a; bus4.valueB  = b; bus4.ciN  = c;
  endtask

  // Issue one command and watch 5 cycles. lat_exp 0 means no done is expected.
  // inject_cyc drops a second start (READ sel 0) in that cycle; reset_cyc pulses reset.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [7:0] c, input int lat_exp, input int inject_cyc,
                       input int reset_cyc);
    logic [31:0] exp[2];
    int          lat[2], pulses[2], idle_bad[2];
    logic [31:0] res[2];
    logic        d[2];
    logic [31:0] r[2];
    for (int k = 0; k < 2; k++) begin
      exp[k] = (op == 2'd2) ? m_read(k, int'(a[2:0])) : 32'd0;
      lat[k] = 0; pulses[k] = 0; idle_bad[k] = 0; res[k] = '0;
    end
    @(negedge clock);
    drive(1'b1, a, {$urandom} & 32'hFFFF_FFFC | 32'(op), c);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clock);
      d[0] = bus24.done; r[0] = bus24.result;
      d[1] = bus4.done;  r[1] = bus4.result;
      for (int k = 0; k < 2; k++) begin
        if (d[k]) begin
          pulses[k]++;
          if (lat[k] == 0) begin lat[k] = cyc; res[k] = r[k]; end
        end else if (r[k] !== 32'd0) begin
          idle_bad[k]++;
        end
      end
      if (cyc == inject_cyc) drive(1'b1, 32'd0, 32'd2, 8'd0);
      else                   drive(1'b0, $urandom, $urandom, 8'd0);
      reset = (cyc == reset_cyc);
    end
    for (int k = 0; k < 2; k++) begin
      string w = (k == 0) ? "w24" : "w4";
      check($sformatf("%s.%s.latency", tag, w), 32'(lat[k]), 32'(lat_exp));
      check($sformatf("%s.%s.pulses", tag, w), 32'(pulses[k]), (lat_exp > 0) ? 32'd1 : 32'd0);
      check($sformatf("%s.%s.idle_result", tag, w), 32'(idle_bad[k]), 32'd0);
      if (lat_exp > 0) check($sformatf("%s.%s.result", tag, w), res[k], exp[k]);
    end
    if (reset_cyc > 0)          m_clear();
    else if (lat_exp == 0)      ;
    else if (op == 2'd0)        m_clear();
    else if (op == 2'd1)        m_acc(a);
  endtask

  task automatic read(input string tag, input int sel);
    issue($sformatf("%s.sel%0d", tag, sel), 2'd2, {$urandom} & 32'hFFFF_FFF8 | 32'(sel),
          8'd0, 1, 0, 0);
  endtask

  initial begin
    m_clear();
    drive(1'b0, '0, '0, '0);
    repeat (3) @(negedge clock);
    check("reset.w24.done", 32'(bus24.done), 32'd0);
    check("reset.w24.result", bus24.result, 32'd0);
    check("reset.w4.done", 32'(bus4.done), 32'd0);
    check("reset.w4.result", bus4.result, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle.w24.done", 32'(bus24.done), 32'd0);
    check("idle.w4.result", bus4.result, 32'd0);

    for (int s = 0; s < 8; s++) read("post_reset", s);

    issue("clear1", 2'd0, 32'd0, 8'd0, 1, 0, 0);
    issue("acc_ff", 2'd1, 32'hFFFF_FFFF, 8'd0, 2, 0, 0);
    for (int s = 0; s < 7; s++) read("after_ff", s);

    issue("clear2", 2'd0, 32'd0, 8'd0, 1, 0, 0);
    issue("acc_1248", 2'd1, 32'h1248_1248, 8'd0, 2, 0, 0);
    for (int s = 0; s < 4; s++) read("after_1248", s);
    issue("acc_22a", 2'd1, 32'h2222_2222, 8'd0, 2, 0, 0);
    issue("acc_22b", 2'd1, 32'h2222_2222, 8'd0, 2, 0, 0);
    read("after_22", 1);
    read("after_22", 4);
    check("net_h_literal", m_read(0, 4), 32'hFFFF_FFF0);

    issue("nop", 2'd3, 32'hDEAD_BEEF, 8'd0, 1, 0, 0);

    issue("clear3", 2'd0, 32'd0, 8'd0, 1, 0, 0);
    issue("sat_a", 2'd1, 32'hFFFF_FFFF, 8'd0, 2, 0, 0);
    issue("sat_b", 2'd1, 32'hFFFF_FFFF, 8'd0, 2, 0, 0);
    for (int s = 0; s < 4; s++) read("sat", s);
    for (int i = 0; i < 18; i++) issue("sat_words", 2'd1, $urandom, 8'd0, 2, 0, 0);
    read("sat_words", 6);

    issue("wrong_ci", 2'd0, 32'd0, 8'h5A, 0, 0, 0);
    read("after_wrong_ci", 0);
    issue("start_in_add", 2'd1, 32'h0000_00F1, 8'd0, 2, 1, 0);
    read("after_add_start", 0);
    issue("start_in_resp", 2'd2, 32'd6, 8'd0, 1, 1, 0);

    issue("reset_in_add", 2'd1, 32'hFFFF_FFFF, 8'd0, 0, 0, 1);
    read("after_reset", 0);
    read("after_reset", 6);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op  = 2'($urandom_range(0, 3));
      logic [7:0]  c   = ($urandom_range(0, 7) == 0) ? 8'h3C : 8'h00;
      logic [31:0] a   = $urandom;
      int          lat = (c != 8'd0) ? 0 : ((op == 2'd1) ? 2 : 1);
      issue($sformatf("rand%0d", i), op, a, c, lat, 0, 0);
    end
    for (int s = 0; s < 8; s++) read("final", s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
